// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - two-wide in-order decode-to-dispatch instruction queue
// Optional perf counters under DECODE_QUEUE_PERF_EN.
module decode_queue #(
  parameter int  DEPTH         = 8,
  parameter int  DECODER_WIDTH = 2,
  parameter type id_dispatch_t = logic [63:0]
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  pause,
  input  logic         [DECODER_WIDTH-1:0]      enq_valid,
  input  id_dispatch_t [DECODER_WIDTH-1:0]      enq_data,
  output logic                                  enq_ready,
  output id_dispatch_t [DECODER_WIDTH-1:0]      deq_data,
  output logic         [DECODER_WIDTH-1:0]      deq_valid,
  input  logic         [DECODER_WIDTH-1:0]      issue_en,
  output logic         [$clog2(DEPTH):0]        count,
  output logic                                  proto_err
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic         [31:0]                   perf_full_cycles,
  output logic         [31:0]                   perf_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  id_dispatch_t  mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count_next;
  logic          do_enq;
  logic [1:0]    n_enq;
  logic [1:0]    n_pop;
  logic [1:0]    pop_mask;
  logic          pop_err;

  always_comb begin
    enq_ready    = (CW'(DEPTH) - count) >= CW'(2);
    deq_valid[0] = count >= CW'(1);
    deq_valid[1] = count >= CW'(2);
    deq_data[0]  = deq_valid[0] ? mem[head_ptr] : '0;
    deq_data[1]  = deq_valid[1] ? mem[head_ptr + AW'(1)] : '0;

    do_enq = enq_ready && !flush;
    n_enq  = do_enq ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]}) : 2'd0;

    // Lane 1 may only retire together with lane 0; a lone lane-1 consume is a protocol fault.
    pop_mask = issue_en & deq_valid;
    n_pop    = 2'd0;
    pop_err  = 1'b0;
    if (!pause && !flush) begin
      case (pop_mask)
        2'b01:   n_pop = 2'd1;
        2'b11:   n_pop = 2'd2;
        2'b10:   pop_err = 1'b1;
        default: n_pop = 2'd0;
      endcase
    end

    count_next = count + CW'(n_enq) - CW'(n_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else if (flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      head_ptr <= head_ptr + AW'(n_pop);
      tail_ptr <= tail_ptr + AW'(n_enq);
      count    <= count_next;
      if (pop_err) proto_err <= 1'b1;
    end
  end

  // Valid lanes are compacted so a lone lane 1 lands at the tail.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      case (enq_valid)
        2'b11: begin
          mem[tail_ptr]          <= enq_data[0];
          mem[tail_ptr + AW'(1)] <= enq_data[1];
        end
        2'b01:   mem[tail_ptr] <= enq_data[0];
        2'b10:   mem[tail_ptr] <= enq_data[1];
        default: ;
      endcase
    end
  end

`ifdef DECODE_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (enq_valid != 2'b00 && !enq_ready && perf_full_cycles != 32'hFFFF_FFFF)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (count == '0 && !flush && perf_empty_cycles != 32'hFFFF_FFFF)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_range: assert (count <= CW'(DEPTH));
      a_no_overflow: assert (flush || count_next <= CW'(DEPTH));
      a_no_underflow: assert (flush || ({1'b0, count} + (CW+1)'(n_enq)) >= (CW+1)'(n_pop));
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - scoreboard bench for decode_queue
// Enable DECODE_QUEUE_PERF_EN to also exercise the perf counters.
module tb_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } id_dispatch_t;

  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic                pause = 1'b0;
  logic [1:0]          enq_valid = 2'b00;
  id_dispatch_t [1:0]  enq_data = '0;
  logic                enq_ready;
  id_dispatch_t [1:0]  deq_data;
  logic [1:0]          deq_valid;
  logic [1:0]          issue_en = 2'b00;
  logic [3:0]          count;
  logic                proto_err;
`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0]         perf_full_cycles;
  logic [31:0]         perf_empty_cycles;
`endif

  decode_queue #(.DEPTH(DEPTH), .DECODER_WIDTH(2), .id_dispatch_t(id_dispatch_t)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .pause     (pause),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_data  (deq_data),
    .deq_valid (deq_valid),
    .issue_en  (issue_en),
    .count     (count),
    .proto_err (proto_err)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  id_dispatch_t  mq[$];
  id_dispatch_t  sb[$];
  logic          m_perr = 1'b0;
  logic [31:0]   pc_seq = 32'h1c00_0000;
  logic [1:0]    mon_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state();
    id_dispatch_t e0, e1;
    int sz;
    sz = mq.size();
    e0 = '0;
    e1 = '0;
    if (sz >= 1) e0 = mq[0];
    if (sz >= 2) e1 = mq[1];
    chk("count", 64'(count), 64'(sz));
    chk("enq_ready", 64'(enq_ready), 64'((DEPTH - sz) >= 2));
    chk("deq_valid", 64'(deq_valid), 64'({sz >= 2, sz >= 1}));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    chk("deq_data0", deq_data[0], e0);
    chk("deq_data1", deq_data[1], e1);
  endtask

  // One clock: drive at posedge+1, update the reference FIFO, check after the next edge.
  task automatic cyc(input logic [1:0] ev, input logic [31:0] pc0, input logic [31:0] pc1,
                     input logic [1:0] ie, input logic p, input logic f);
    id_dispatch_t e0, e1, tmp;
    int sz;
    logic [1:0] m;
    #1;
    e0 = '{pc: pc0, inst: $urandom};
    e1 = '{pc: pc1, inst: $urandom};
    enq_valid   = ev;
    enq_data[0] = e0;
    enq_data[1] = e1;
    issue_en    = ie;
    pause       = p;
    flush       = f;
    sz = mq.size();
    if (f) begin
      mq.delete();
      sb.delete();
      m_perr = 1'b0;
    end else begin
      if (!p) begin
        m = ie & {sz >= 2, sz >= 1};
        if (m == 2'b01) tmp = mq.pop_front();
        else if (m == 2'b11) begin
          tmp = mq.pop_front();
          tmp = mq.pop_front();
        end else if (m == 2'b10) m_perr = 1'b1;
      end
      if (DEPTH - sz >= 2) begin
        if (ev[0]) begin mq.push_back(e0); sb.push_back(e0); end
        if (ev[1]) begin mq.push_back(e1); sb.push_back(e1); end
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  function automatic logic [31:0] npc();
    npc = pc_seq;
    pc_seq = pc_seq + 32'd4;
  endfunction

  // Monitor: every entry dispatch actually consumes must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst && !flush && !pause) begin
      mon_m = issue_en & deq_valid;
      if (mon_m[0]) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_lane0: got %h expected nothing", deq_data[0]);
        end else chk("sb_lane0", deq_data[0], sb.pop_front());
        if (mon_m[1]) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_lane1: got %h expected nothing", deq_data[1]);
          end else chk("sb_lane1", deq_data[1], sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, pf0;
    logic [1:0]  ev, ie;
    logic        p, f;

    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_data", deq_data, '0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full with ordered pairs.
    for (int i = 0; i < 4; i++) begin
      a = npc(); b = npc();
      cyc(2'b11, a, b, 2'b00, 1'b0, 1'b0);
    end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_ready", 64'(enq_ready), 64'd0);
    chk("fill_pc0", 64'(deq_data[0].pc), 64'h1c00_0000);
    chk("fill_pc1", 64'(deq_data[1].pc), 64'h1c00_0004);

    // Stall while full: enqueue must be dropped.
`ifdef DECODE_QUEUE_PERF_EN
    pf0 = perf_full_cycles;
`else
    pf0 = 32'd0;
`endif
    for (int i = 0; i < 5; i++) cyc(2'b11, 32'hdead_0000, 32'hdead_0004, 2'b00, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_PERF_EN
    chk("perf_full", 64'(perf_full_cycles - pf0), 64'd5);
`endif

    // Drain mixed.
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("drain1_count", 64'(count), 64'd6);
    chk("drain1_pc", 64'(deq_data[0].pc), 64'h1c00_0008);
    cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("drain2_count", 64'(count), 64'd5);
    chk("drain2_pc", 64'(deq_data[0].pc), 64'h1c00_000c);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("drain3_count", 64'(count), 64'd3);
    chk("drain3_pc", 64'(deq_data[0].pc), 64'h1c00_0014);
    cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);

    // Steady flow across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      a = npc(); b = npc();
      cyc(2'b11, a, b, 2'b11, 1'b0, 1'b0);
      chk("steady_count", 64'(count), 64'd2);
    end

    // Compaction of a lone lane 1 into an empty queue.
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    cyc(2'b10, 32'h0bad_0000, 32'h1c00_0100, 2'b00, 1'b0, 1'b0);
    chk("compact_valid", 64'(deq_valid), 64'b01);
    chk("compact_pc", 64'(deq_data[0].pc), 64'h1c00_0100);
    chk("compact_lane1", deq_data[1], '0);

    // Pause holds entries but still admits enqueue; flush empties.
    a = npc(); b = npc();
    cyc(2'b11, a, b, 2'b00, 1'b0, 1'b0);
    a = npc();
    cyc(2'b01, a, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
    chk("pause_count", 64'(count), 64'd4);
    a = npc(); b = npc();
    cyc(2'b11, a, b, 2'b11, 1'b1, 1'b0);
    chk("pause_enq_count", 64'(count), 64'd6);
    cyc(2'b11, 32'h1, 32'h2, 2'b11, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deq_valid), 64'd0);

    // Protocol error: lane 1 without lane 0.
    a = npc(); b = npc();
    cyc(2'b11, a, b, 2'b00, 1'b0, 1'b0);
    a = npc();
    cyc(2'b01, a, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("perr_count", 64'(count), 64'd3);
    chk("perr_flag", 64'(proto_err), 64'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("perr_sticky", 64'(proto_err), 64'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("perr_flush", 64'(proto_err), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ev = 2'($urandom_range(0, 3));
      ie = 2'($urandom_range(0, 3));
      p  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 39) == 0);
      a = npc(); b = npc();
      cyc(ev, a, b, ie, p, f);
    end

    // Asynchronous reset pulse mid-stream.
    a = npc(); b = npc();
    cyc(2'b11, a, b, 2'b10, 1'b0, 1'b0);
    #1;
    enq_valid = 2'b00; issue_en = 2'b00; pause = 1'b0; flush = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_deq_data", deq_data, '0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    chk("arst_proto_err", 64'(proto_err), 64'd0);
    mq.delete();
    sb.delete();
    m_perr = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_state();

    for (int i = 0; i < 60; i++) begin
      ev = 2'($urandom_range(0, 3));
      ie = 2'($urandom_range(0, 3));
      a = npc(); b = npc();
      cyc(ev, a, b, ie, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
